// File: rtl/deser_pkg.sv
// Shared definitions for the serial-requester arbiter in front of the
// 16-bit deserializer: FSM state type and default frame/timeout sizes.
package deser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } deser_arb_state_t;

  localparam int FRAME_LEN_DEF    = 16;
  localparam int IDLE_TIMEOUT_DEF = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req         - per-channel request vector
//   last_winner - channel granted most recently; search starts one above it
//   winner      - index of the first requesting channel found (wraps)
//   valid       - at least one request is set
module rr_pick #(
  parameter int N_CH = 4,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last_winner,
  output logic [CH_W-1:0] winner,
  output logic            valid
);

  always_comb begin : pick
    int idx;
    logic [CH_W-1:0] sel;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    // Offsets 1..N_CH visit every channel once, ending on last_winner itself.
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_winner) + i) % N_CH;
      sel = CH_W'(idx);
      if (!valid && req[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/deser_arbiter.sv
// Arbitrates N_CH serial requesters onto one shared deserializer input.
// A granted channel forwards FRAME_LEN qualified bits; the frame is aborted
// when the requester drops its request or stays silent for IDLE_TIMEOUT cycles.
// Ports:
//   clk_i, arst_i        - clock, asynchronous active-high reset
//   req_i                - per-channel frame request
//   data_i, data_val_i   - per-channel serial bit and qualifier
//   gnt_o                - registered one-hot grant
//   ser_data_o/_val_o    - registered muxed bit and qualifier
//   frame_done_o         - pulse: full frame forwarded
//   abort_o              - pulse: frame abandoned, deserializer must clear
//   frame_ch_o           - channel index qualifying done/abort
//
// state | meaning
// IDLE  | no grant; arbitrate among requesters
// BUSY  | winner granted; forwarding its qualified bits
// GAP   | one dead cycle after done/abort before re-arbitration
module deser_arbiter import deser_pkg::*; #(
  parameter int N_CH         = 4,
  parameter int FRAME_LEN    = FRAME_LEN_DEF,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] data_i,
  input  logic [N_CH-1:0] data_val_i,
  output logic [N_CH-1:0] gnt_o,
  output logic            ser_data_o,
  output logic            ser_data_val_o,
  output logic            frame_done_o,
  output logic            abort_o,
  output logic [CH_W-1:0] frame_ch_o
);

  localparam int BC_W = $clog2(FRAME_LEN + 1);
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_LEN - 1);
  localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(IDLE_TIMEOUT - 1);

  deser_arb_state_t state, nxt_state;
  logic [N_CH-1:0]  gnt_q, nxt_gnt;
  logic [CH_W-1:0]  winner_q, nxt_winner;
  logic [BC_W-1:0]  bit_cnt, nxt_bit_cnt;
  logic [IC_W-1:0]  idle_cnt, nxt_idle_cnt;
  logic             ser_data_q, nxt_ser_data;
  logic             ser_val_q, nxt_ser_val;
  logic             done_q, nxt_done;
  logic             abort_q, nxt_abort;
  logic [CH_W-1:0]  frame_ch_q, nxt_frame_ch;

  logic [CH_W-1:0]  pick;
  logic             pick_valid;
  logic             accepted;
  logic             req_held;

  rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_rr_pick (
    .req         (req_i),
    .last_winner (winner_q),
    .winner      (pick),
    .valid       (pick_valid)
  );

  assign accepted = data_val_i[winner_q];
  assign req_held = req_i[winner_q];

  always_comb begin
    nxt_state    = state;
    nxt_gnt      = gnt_q;
    nxt_winner   = winner_q;
    nxt_bit_cnt  = bit_cnt;
    nxt_idle_cnt = idle_cnt;
    nxt_ser_data = 1'b0;
    nxt_ser_val  = 1'b0;
    nxt_done     = 1'b0;
    nxt_abort    = 1'b0;
    nxt_frame_ch = frame_ch_q;
    case (state)
      ST_IDLE: begin
        nxt_gnt = '0;
        if (pick_valid) begin
          nxt_state     = ST_BUSY;
          nxt_gnt[pick] = 1'b1;
          nxt_winner    = pick;
          nxt_bit_cnt   = '0;
          nxt_idle_cnt  = '0;
        end
      end
      ST_BUSY: begin
        if (accepted) begin
          nxt_ser_data = data_i[winner_q];
          nxt_ser_val  = 1'b1;
          nxt_bit_cnt  = bit_cnt + 1'b1;
          nxt_idle_cnt = '0;
        end else begin
          nxt_idle_cnt = idle_cnt + 1'b1;
        end
        // Completing the frame wins over a simultaneous request drop.
        if (accepted && bit_cnt == BIT_LAST) begin
          nxt_state    = ST_GAP;
          nxt_gnt      = '0;
          nxt_done     = 1'b1;
          nxt_frame_ch = winner_q;
        end else if (!req_held || (!accepted && idle_cnt == IDLE_LAST)) begin
          nxt_state    = ST_GAP;
          nxt_gnt      = '0;
          nxt_abort    = 1'b1;
          nxt_frame_ch = winner_q;
        end
      end
      ST_GAP: begin
        nxt_state = ST_IDLE;
        nxt_gnt   = '0;
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_gnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      winner_q   <= CH_W'(N_CH - 1);
      bit_cnt    <= '0;
      idle_cnt   <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      frame_ch_q <= '0;
    end else begin
      state      <= nxt_state;
      gnt_q      <= nxt_gnt;
      winner_q   <= nxt_winner;
      bit_cnt    <= nxt_bit_cnt;
      idle_cnt   <= nxt_idle_cnt;
      ser_data_q <= nxt_ser_data;
      ser_val_q  <= nxt_ser_val;
      done_q     <= nxt_done;
      abort_q    <= nxt_abort;
      frame_ch_q <= nxt_frame_ch;
    end
  end

  assign gnt_o          = gnt_q;
  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign frame_done_o   = done_q;
  assign abort_o        = abort_q;
  assign frame_ch_o     = frame_ch_q;

endmodule

// File: doc/deser_arbiter.md
DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 Parameter N_CH, default 4: number of serial requesters sharing one 16-bit deserializer.
REQ-002 Parameter FRAME_LEN, default 16: serial bits per frame.
REQ-003 Parameter IDLE_TIMEOUT, default 32: consecutive no-valid cycles in BUSY that abort a frame.
REQ-004 clk_i  input  1  single clock; all logic on the rising edge.
REQ-005 arst_i  input  1  reset, asynchronous and active-high.
REQ-006 req_i  input  N_CH  per-channel request for a frame slot.
REQ-007 data_i  input  N_CH  per-channel serial data bit.
REQ-008 data_val_i  input  N_CH  per-channel serial bit qualifier.
REQ-009 gnt_o  output  N_CH  one-hot grant, registered.
REQ-010 ser_data_o  output  1  muxed serial bit to the deserializer, registered.
REQ-011 ser_data_val_o  output  1  muxed bit qualifier to the deserializer, registered.
REQ-012 frame_done_o  output  1  one-cycle pulse, FRAME_LEN bits forwarded.
REQ-013 abort_o  output  1  one-cycle pulse, frame abandoned; the deserializer must be cleared.
REQ-014 frame_ch_o  output  $clog2(N_CH)  channel index, valid with frame_done_o or abort_o.

Function
REQ-015 FSM states IDLE, BUSY, GAP; reset state IDLE.
REQ-016 IDLE: if any req_i bit is set, winner = first set bit searching from (last_winner+1) mod N_CH upward with wrap; next cycle gnt_o = one-hot(winner), state BUSY, last_winner <= winner.
REQ-017 IDLE with req_i == 0: remain IDLE, gnt_o = 0.
REQ-018 BUSY: a bit is accepted when data_val_i[winner] = 1; the next cycle ser_data_o = data_i[winner] and ser_data_val_o = 1 (1-cycle latency).
REQ-019 data_i and data_val_i of non-granted channels are ignored and never reach ser_data_*.
REQ-020 Bit counter width $clog2(FRAME_LEN+1); it increments per accepted bit and clears on entry to BUSY.
REQ-021 The FRAME_LEN-th accepted bit moves the FSM to GAP. In the following cycle: gnt_o = 0, ser_data_val_o = 1 (last bit), frame_done_o = 1, frame_ch_o = winner.
REQ-022 Idle counter counts consecutive BUSY cycles without an accepted bit and clears on each accepted bit.
REQ-023 When the idle counter reaches IDLE_TIMEOUT: move to GAP; next cycle abort_o = 1, frame_ch_o = winner, gnt_o = 0.
REQ-024 req_i[winner] deasserting in BUSY before the frame completes aborts as in REQ-023.
REQ-025 If an accepted bit and a req_i drop occur in the same cycle, the bit is forwarded and the frame aborts. Exception: if that bit is the FRAME_LEN-th, frame_done_o takes priority and abort_o is not asserted.
REQ-026 GAP lasts exactly one cycle with gnt_o = 0, then IDLE. The minimum spacing between grants is 2 cycles.
REQ-027 frame_done_o and abort_o are never asserted together; each is a single-cycle pulse.
REQ-028 gnt_o is always zero or one-hot.

Reset
REQ-029 While arst_i is high, regardless of clk_i: state IDLE; gnt_o, ser_data_o, ser_data_val_o, frame_done_o, abort_o, frame_ch_o = 0; counters = 0; last_winner = N_CH-1, so channel 0 has first priority.
REQ-030 arst_i asserted mid-frame discards the frame with no frame_done_o or abort_o. Downstream deserializer recovery is the integrator's responsibility.
REQ-031 Deassertion is synchronised externally; the first request is arbitrated on the first rising edge after release.

Structure
REQ-032 The shared package deser_pkg holds: the FSM state enum deser_arb_state_t, FRAME_LEN_DEF = 16, and IDLE_TIMEOUT_DEF = 32.
REQ-033 One sub-module, rr_pick: combinational round-robin selector with inputs req and last_winner, output winner index and a valid flag. Everything else stays in deser_arbiter.

Verification
REQ-034 Single channel: req_i = 0001, then 16 valid bits 0xA5C3 LSB-first -> gnt_o = 0001 one cycle after req; ser_data_o reproduces the 16 bits with 1-cycle latency; frame_done_o pulses with frame_ch_o = 0 together with the 16th ser_data_val_o.
REQ-035 All channels request continuously, each sending full frames -> grant order 0,1,2,3,0; gnt_o never multi-hot; 2 gnt-low cycles between frames.
REQ-036 Ch2 granted, sends 5 bits, then no valid bits for 32 cycles -> abort_o pulses with frame_ch_o = 2; next arbitration starts from ch3.
REQ-037 Ch1 granted; ch0 toggles data_val_i with data 1s throughout -> no ch0 bit appears on ser_data_o; ch1 frame completes intact.
REQ-038 arst_i pulsed (not clock-aligned) after 8 bits of a ch3 frame -> all outputs 0 immediately; no done/abort pulse; after release, req_i = 1111 grants ch0.
REQ-039 Ch0 16th bit accepted in the same cycle req_i[0] drops -> frame_done_o = 1, abort_o = 0.
